// File: rtl/mode_switch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mode_switch_pkg
// Description : Shared types and constants for the front-panel mode switch.
//               Holds the two-state controller encoding, the bit offsets of
//               each field inside the 28-bit peripheral bundle and the
//               default "safe" bundle driven while a switch is in progress.
// Revision    : 1.0 - initial release
// ============================================================================
package mode_switch_pkg;

    // Controller states, explicitly encoded on one bit.
    typedef enum logic [0:0] {
        RUN  = 1'b0,
        HOLD = 1'b1
    } state_t;

    // Bundle layout:
    // {col[3:0], led[4:1], seg_sel[7:0], seg_led[7:0],
    //  oled_rst, oled_dcn, oled_clk, oled_dat}
    localparam int COL_LSB      = 24;
    localparam int LED_LSB      = 20;
    localparam int SEL_LSB      = 12;
    localparam int SEG_LSB      = 4;
    localparam int OLED_RST_BIT = 3;
    localparam int OLED_DCN_BIT = 2;
    localparam int OLED_CLK_BIT = 1;
    localparam int OLED_DAT_BIT = 0;

    // Columns idle high, LEDs off, segment selects and segments blank,
    // OLED held in reset with its serial lines parked low.
    localparam logic [27:0] SAFE_VAL_DEFAULT = {
        4'hF,   // col
        4'h0,   // led
        8'hFF,  // seg_sel
        8'hFF,  // seg_led
        1'b0,   // oled_rst (asserted)
        1'b0,   // oled_dcn
        1'b0,   // oled_clk
        1'b0    // oled_dat
    };

endpackage : mode_switch_pkg
`default_nettype wire

// File: rtl/key_debounce.sv
`default_nettype none
// ============================================================================
// Module      : key_debounce
// Description : Two-flop synchroniser followed by a level debouncer for one
//               active-low key. A change of the accepted level needs the
//               synchronised input to differ from it for DEB_CYCLES
//               consecutive cycles. Accepting a low level emits a single
//               one-cycle press pulse; accepting a high level emits nothing,
//               so a key must be released before it can fire again.
// Ports       : clk         in   system clock
//               rst_n       in   synchronous active-low reset
//               key_n       in   raw asynchronous key, low = pressed
//               press_pulse out  registered one-cycle press event
// Revision    : 1.0 - initial release
// ============================================================================
module key_debounce #(
    parameter logic [19:0] DEB_CYCLES = 20'd1_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_n,
    output logic press_pulse
);

    localparam logic [19:0] c_DEB_LAST = DEB_CYCLES - 20'd1;

    logic        r_sync1;
    logic        r_sync2;
    logic        r_stable;   // accepted key level, 1 = released
    logic        r_pulse;
    logic [19:0] r_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sync1  <= 1'b1;
            r_sync2  <= 1'b1;
            r_stable <= 1'b1;
            r_pulse  <= 1'b0;
            r_cnt    <= '0;
        end else begin
            r_sync1 <= key_n;
            r_sync2 <= r_sync1;
            r_pulse <= 1'b0;
            // Any return to the accepted level restarts the stability count,
            // which is what rejects bounce.
            if (r_sync2 == r_stable) begin
                r_cnt <= '0;
            end else if (r_cnt == c_DEB_LAST) begin
                r_stable <= r_sync2;
                r_cnt    <= '0;
                r_pulse  <= ~r_sync2;
            end else begin
                r_cnt <= r_cnt + 20'd1;
            end
        end
    end

    assign press_pulse = r_pulse;

endmodule : key_debounce
`default_nettype wire

// File: rtl/mode_switch_mux.sv
`default_nettype none
// ============================================================================
// Module      : mode_switch_mux
// Description : N-channel front-panel arbiter. Selects one measurement
//               engine's peripheral bundle from debounced next/prev keys or
//               a direct select strobe. Each switch drives a safe bundle for
//               HOLD_CYCLES and holds the new engine in reset for the same
//               window so its OLED re-initialises cleanly.
// Ports       : sys_clk     in   system clock
//               sys_rst_n   in   synchronous active-low reset
//               key_next_n  in   raw next key, active-low, asynchronous
//               key_prev_n  in   raw prev key, active-low, asynchronous
//               sel_req     in   one-cycle direct select strobe
//               sel_idx     in   channel index for sel_req
//               ch_bus      in   engine bundles, channel k at [k*BUS_W +: BUS_W]
//               out_bus     out  registered bundle to the pins
//               ch_rst_n    out  per-engine re-init reset, active-low
//               mode        out  currently selected channel
//               switching   out  high while the safe window is active
// Revision    : 1.0 - initial release
// ============================================================================
module mode_switch_mux
    import mode_switch_pkg::*;
#(
    parameter int              N_CH        = 2,
    parameter int              BUS_W       = 28,
    parameter logic [BUS_W-1:0] SAFE_VAL   = BUS_W'(SAFE_VAL_DEFAULT),
    parameter logic [19:0]     DEB_CYCLES  = 20'd1_000_000,
    parameter logic [15:0]     HOLD_CYCLES = 16'd50_000,
    parameter int              DEFAULT_CH  = 0,
    localparam int             CH_W        = (N_CH > 2) ? $clog2(N_CH) : 1
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst_n,
    input  logic                  key_next_n,
    input  logic                  key_prev_n,
    input  logic                  sel_req,
    input  logic [CH_W-1:0]       sel_idx,
    input  logic [N_CH*BUS_W-1:0] ch_bus,
    output logic [BUS_W-1:0]      out_bus,
    output logic [N_CH-1:0]       ch_rst_n,
    output logic [CH_W-1:0]       mode,
    output logic                  switching
);

    localparam logic [15:0]     c_HOLD_LAST = HOLD_CYCLES - 16'd1;
    localparam logic [31:0]     c_N_CH      = N_CH;
    localparam logic [CH_W-1:0] c_LAST_CH   = CH_W'(N_CH - 1);

    logic w_next_evt;
    logic w_prev_evt;

    key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_next_deb (
        .clk         (sys_clk),
        .rst_n       (sys_rst_n),
        .key_n       (key_next_n),
        .press_pulse (w_next_evt)
    );

    key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_prev_deb (
        .clk         (sys_clk),
        .rst_n       (sys_rst_n),
        .key_n       (key_prev_n),
        .press_pulse (w_prev_evt)
    );

    state_t           r_state;
    logic [CH_W-1:0]  r_mode;
    logic [BUS_W-1:0] r_out_bus;
    logic [N_CH-1:0]  r_ch_rst_n;
    logic             r_switching;
    logic [15:0]      r_hold_cnt;

    // Bundle of the currently selected channel.
    logic [BUS_W-1:0] w_sel_bus;
    always_comb begin
        w_sel_bus = ch_bus[BUS_W-1:0];
        for (int k = 1; k < N_CH; k++) begin
            if (r_mode == CH_W'(k)) begin
                w_sel_bus = ch_bus[k*BUS_W +: BUS_W];
            end
        end
    end

    // Request arbitration: a valid direct select wins; an invalid or
    // redundant one falls through to the keys. Simultaneous next and prev
    // events cancel.
    logic            w_sel_ok;
    logic            w_req;
    logic [CH_W-1:0] w_target;
    always_comb begin
        w_sel_ok = sel_req && (32'(sel_idx) < c_N_CH) && (sel_idx != r_mode);
        w_req    = 1'b0;
        w_target = r_mode;
        if (w_sel_ok) begin
            w_req    = 1'b1;
            w_target = sel_idx;
        end else if (w_next_evt && !w_prev_evt) begin
            w_req    = 1'b1;
            w_target = (r_mode == c_LAST_CH) ? '0 : r_mode + CH_W'(1);
        end else if (w_prev_evt && !w_next_evt) begin
            w_req    = 1'b1;
            w_target = (r_mode == '0) ? c_LAST_CH : r_mode - CH_W'(1);
        end
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            r_state     <= RUN;
            r_mode      <= CH_W'(DEFAULT_CH);
            r_out_bus   <= SAFE_VAL;
            r_ch_rst_n  <= '1;
            r_switching <= 1'b0;
            r_hold_cnt  <= '0;
        end else begin
            case (r_state)
                RUN: begin
                    if (w_req) begin
                        r_state     <= HOLD;
                        r_mode      <= w_target;
                        r_hold_cnt  <= '0;
                        r_switching <= 1'b1;
                        r_ch_rst_n  <= ~(N_CH'(1) << w_target);
                        r_out_bus   <= SAFE_VAL;
                    end else begin
                        r_out_bus <= w_sel_bus;
                    end
                end
                HOLD: begin
                    // Keys and strobes seen here are simply not looked at,
                    // so they are dropped rather than queued.
                    r_out_bus <= SAFE_VAL;
                    if (r_hold_cnt == c_HOLD_LAST) begin
                        r_state     <= RUN;
                        r_switching <= 1'b0;
                        r_ch_rst_n  <= '1;
                        r_hold_cnt  <= '0;
                    end else begin
                        r_hold_cnt <= r_hold_cnt + 16'd1;
                    end
                end
                default: r_state <= RUN;
            endcase
        end
    end

    assign out_bus   = r_out_bus;
    assign ch_rst_n  = r_ch_rst_n;
    assign mode      = r_mode;
    assign switching = r_switching;

endmodule : mode_switch_mux
`default_nettype wire
